// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch sequencer driving the instruction register load side
//
// Holds the program counter, presents it to a synchronous ROM, waits one
// cycle for the read data, then pulses the instruction register load strobe.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   fetch request, sampled only in IDLE
//   jmp_en     in   load pc from jmp_addr, honoured only in IDLE
//   jmp_addr   in   jump target
//   rom_addr   out  ROM read address (= pc)
//   rom_q      in   ROM read data, valid one cycle after rom_addr is sampled
//   ir_data    out  instruction register data (= rom_q)
//   ir_ld      out  instruction register load strobe, one-cycle pulse
//   done       out  fetch complete, coincident with ir_ld
//   busy       out  high in FETCH and LOAD
//   pc         out  current program counter
//   fetch_cnt  out  completed fetch count, saturating
module instr_fetch_unit #(
  parameter int ADDR_W  = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               jmp_en,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_q,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_ld,
  output logic               done,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // A jump and a start on the same edge: FETCH then reads the jump target.
        if (jmp_en) pc_d = jmp_addr;
        if (start)  state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pc_d    = pc_q + PC_ONE;  // wraps naturally at 2^ADDR_W
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset during LOAD removes ir_ld without waiting for a clock edge.
  assign ir_ld     = (state_q == S_LOAD);
  assign done      = (state_q == S_LOAD);
  assign busy      = (state_q == S_FETCH) || (state_q == S_LOAD);
  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign ir_data   = rom_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        jmp_en = 1'b0;
  logic [6:0]  jmp_addr = '0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_q = '0;
  logic [15:0] ir_data;
  logic        ir_ld;
  logic        done;
  logic        busy;
  logic [6:0]  pc;
  logic [15:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  instr_fetch_unit #(.ADDR_W(7), .INSTR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .ir_data   (ir_data),
    .ir_ld     (ir_ld),
    .done      (done),
    .busy      (busy),
    .pc        (pc),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with ROM[a] = 16'hA000 + a.
  always @(posedge clk) begin
    rom_q <= 16'hA000 + {9'd0, rom_addr};
    cyc   <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard: every load strobe must match a queued fetch.
  always @(negedge clk) begin
    if (!reset) begin
      check("done_eq_ir_ld", {31'd0, done}, {31'd0, ir_ld});
      if (ir_ld) begin
        if (sb_q.size() == 0) begin
          check("spurious_ir_ld", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ir_data", {16'd0, ir_data}, {16'd0, e.data});
          check("ir_ld_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc", {25'd0, pc}, 32'd0);
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    check("rst_ir_ld", {31'd0, ir_ld}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
  endtask

  // One fetch from IDLE; returns at the negedge where the DUT is back in IDLE.
  task automatic fetch(input logic jmp, input logic [6:0] addr, input logic [15:0] exp_data,
                       input logic noisy);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    jmp_en = jmp;
    jmp_addr = addr;
    e.data = exp_data;
    e.cyc  = cyc + 2;
    sb_q.push_back(e);
    @(negedge clk);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    check("fetch_no_ld", {31'd0, ir_ld}, 32'd0);
    // In FETCH and LOAD both inputs must be ignored.
    start = noisy;
    jmp_en = noisy;
    jmp_addr = 7'h10;
    @(negedge clk);
    check("load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    jmp_en = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single fetch from address 0.
    fetch(1'b0, 7'h00, 16'hA000, 1'b0);
    check("single_pc", {25'd0, pc}, 32'd1);
    check("single_cnt", {16'd0, fetch_cnt}, 32'd1);
    check("single_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: start held for 12 edges gives four fetches.
    do_reset();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = 16'hA000 + 16'(i);
      e.cyc  = cyc + 2 + 3 * i;
      sb_q.push_back(e);
    end
    repeat (12) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b_pc", {25'd0, pc}, 32'd4);
    check("b2b_cnt", {16'd0, fetch_cnt}, 32'd4);

    // Jump and start in the same IDLE cycle.
    fetch(1'b1, 7'h50, 16'hA050, 1'b0);
    check("jmp_start_pc", {25'd0, pc}, 32'h51);
    check("jmp_start_cnt", {16'd0, fetch_cnt}, 32'd5);

    // start/jmp_en during FETCH and LOAD are ignored.
    fetch(1'b0, 7'h00, 16'hA051, 1'b1);
    check("ign_pc", {25'd0, pc}, 32'h52);
    check("ign_cnt", {16'd0, fetch_cnt}, 32'd6);
    repeat (2) @(negedge clk);
    check("ign_no_refetch_pc", {25'd0, pc}, 32'h52);

    // Jump alone, then wrap across the top of the address space.
    @(negedge clk);
    jmp_en = 1'b1;
    jmp_addr = 7'h7F;
    @(negedge clk);
    jmp_en = 1'b0;
    check("jmp_only_pc", {25'd0, pc}, 32'h7F);
    check("jmp_only_idle", {31'd0, busy}, 32'd0);
    fetch(1'b0, 7'h00, 16'hA07F, 1'b0);
    check("wrap_pc0", {25'd0, pc}, 32'h00);
    fetch(1'b0, 7'h00, 16'hA000, 1'b0);
    check("wrap_pc1", {25'd0, pc}, 32'h01);
    check("wrap_cnt", {16'd0, fetch_cnt}, 32'd8);

    // Reset asserted during LOAD aborts the fetch with no strobe.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_ir_ld", {31'd0, ir_ld}, 32'd1);
    check("pre_rst_pc", {25'd0, pc}, 32'h01);
    reset = 1'b1;
    #1;
    check("midrst_ir_ld", {31'd0, ir_ld}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_pc", {25'd0, pc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_pc", {25'd0, pc}, 32'd0);
    check("post_rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
